// File: rtl/csa_mult_arbiter.sv
// rtl/csa_mult_arbiter.sv - round-robin arbiter sharing one external 4x4 signed multiplier
module csa_mult_arbiter #(
  parameter int NREQ = 4,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [4*NREQ-1:0] req_a,
  input  logic [4*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [3:0]        mul_a,
  output logic [3:0]        mul_b,
  input  logic [7:0]        mul_p,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [7:0]        rsp_p,
  input  logic              rsp_ready,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] rr_ptr, op_id, winner, idx;
  logic           found, can_accept, accept;

  // Rotating priority search; IDW-bit addition wraps because NREQ is a power of two.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = rr_ptr + IDW'(k);
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign can_accept = (state == IDLE) || (state == RESP && rsp_ready);
  assign accept     = rst_n && can_accept && found;
  assign busy       = (state != IDLE);

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[winner] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = MUL;
      MUL:  state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = accept ? MUL : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Only the winner's operand slice is ever sampled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      op_id     <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_p     <= '0;
    end else begin
      if (state == MUL) begin
        rsp_p     <= mul_p;
        rsp_id    <= op_id;
        rsp_valid <= 1'b1;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
      if (accept) begin
        mul_a  <= req_a[{winner, 2'b00} +: 4];
        mul_b  <= req_b[{winner, 2'b00} +: 4];
        op_id  <= winner;
        rr_ptr <= winner + IDW'(1);
      end
    end
  end

endmodule

// File: tb/tb_csa_mult_arbiter.sv
// tb/tb_csa_mult_arbiter.sv - randomized and directed check of csa_mult_arbiter against a transaction model
module tb_csa_mult_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [15:0] req_a, req_b;
  logic [3:0]  req_ready;
  logic [3:0]  mul_a, mul_b;
  logic [7:0]  mul_p;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_p;
  logic        rsp_ready;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // External multiplier stand-in: sign-extend both operands to 8 bits.
  logic signed [7:0] sa, sb;
  assign sa    = {{4{mul_a[3]}}, mul_a};
  assign sb    = {{4{mul_b[3]}}, mul_b};
  assign mul_p = sa * sb;

  csa_mult_arbiter #(.NREQ(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_p(rsp_p), .rsp_ready(rsp_ready),
    .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction model: phase 0 = nothing outstanding, 1 = operands taken, 2 = response shown.
  int         m_phase, m_ptr, m_op_id, m_rsp_id;
  logic [7:0] m_op_p, m_rsp_p;
  logic [3:0] m_a, m_b;
  logic [3:0] obs_ready;
  logic       obs_valid;
  logic [1:0] obs_id;
  logic [7:0] obs_p;

  function automatic int sval(input logic [3:0] x);
    return x[3] ? int'(x) - 16 : int'(x);
  endfunction

  task automatic model_reset();
    m_phase = 0; m_ptr = 0; m_op_id = 0; m_rsp_id = 0;
    m_op_p = 0; m_rsp_p = 0; m_a = 0; m_b = 0;
  endtask

  task automatic step(input logic [3:0] v, input logic [15:0] a, input logic [15:0] b,
                      input logic rr, input logic rst);
    bit   can;
    int   w;
    logic [3:0] exp_ready;
    @(negedge clk);
    req_valid = v; req_a = a; req_b = b; rsp_ready = rr; rst_n = rst;
    #1;
    can = (m_phase == 0) || (m_phase == 2 && rr);
    w = -1;
    for (int k = 0; k < 4; k++)
      if (w < 0 && v[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
    exp_ready = (rst && can && w >= 0) ? (4'b0001 << w) : 4'b0000;
    check("req_ready", {28'b0, req_ready}, {28'b0, exp_ready});
    check("rsp_valid", {31'b0, rsp_valid}, {31'b0, m_phase == 2});
    check("busy", {31'b0, busy}, {31'b0, m_phase != 0});
    check("rsp_id", {30'b0, rsp_id}, 32'(m_rsp_id));
    check("rsp_p", {24'b0, rsp_p}, {24'b0, m_rsp_p});
    check("mul_a", {28'b0, mul_a}, {28'b0, m_a});
    check("mul_b", {28'b0, mul_b}, {28'b0, m_b});
    obs_ready = req_ready; obs_valid = rsp_valid; obs_id = rsp_id; obs_p = rsp_p;
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      if (m_phase == 1) begin
        m_rsp_p = m_op_p; m_rsp_id = m_op_id; m_phase = 2;
      end else if (m_phase == 2 && rr) begin
        m_phase = 0;
      end
      if (can && w >= 0) begin
        m_a = a[w*4 +: 4];
        m_b = b[w*4 +: 4];
        m_op_id = w;
        m_op_p = 8'(sval(m_a) * sval(m_b));
        m_ptr = (w + 1) % 4;
        m_phase = 1;
      end
    end
  endtask

  // One request through requester id, then two idle cycles; last step observes the response.
  task automatic run_one(input int id, input logic [3:0] a, input logic [3:0] b);
    logic [15:0] pa, pb;
    pa = 16'h0; pb = 16'h0;
    pa[id*4 +: 4] = a;
    pb[id*4 +: 4] = b;
    step(4'b0001 << id, pa, pb, 1'b1, 1'b1);
    step(4'b0000, 16'h0, 16'h0, 1'b1, 1'b1);
    step(4'b0000, 16'h0, 16'h0, 1'b1, 1'b1);
  endtask

  initial begin
    logic [3:0] grants [6];
    int gi;
    model_reset();
    req_valid = 0; req_a = 0; req_b = 0; rsp_ready = 0; rst_n = 0;
    step(4'b0000, 16'h0, 16'h0, 1'b0, 1'b0);
    step(4'b1111, 16'h0, 16'h0, 1'b1, 1'b0);
    check("reset_ready_zero", {28'b0, obs_ready}, 32'h0);

    // Single request from requester 2: 3 * -2.
    step(4'b0100, 16'h0300, 16'h0E00, 1'b1, 1'b1);
    check("single_grant", {28'b0, obs_ready}, 32'h4);
    step(4'b0000, 16'h0, 16'h0, 1'b1, 1'b1);
    step(4'b0000, 16'h0, 16'h0, 1'b1, 1'b1);
    check("single_valid", {31'b0, obs_valid}, 32'h1);
    check("single_id", {30'b0, obs_id}, 32'h2);
    check("single_p", {24'b0, obs_p}, 32'hFA);

    run_one(0, 4'h8, 4'h8);
    check("corner_m8m8", {24'b0, obs_p}, 32'h40);
    run_one(0, 4'h7, 4'h8);
    check("corner_7m8", {24'b0, obs_p}, 32'hC8);
    run_one(0, 4'h0, 4'h8);
    check("corner_0m8", {24'b0, obs_p}, 32'h00);

    // Round robin from a fresh pointer.
    step(4'b0000, 16'h0, 16'h0, 1'b1, 1'b0);
    gi = 0;
    for (int c = 0; c < 12; c++) begin
      step(4'b1111, 16'h7531, 16'h9BDF, 1'b1, 1'b1);
      if (obs_ready != 0 && gi < 6) begin grants[gi] = obs_ready; gi++; end
    end
    check("rr_count", 32'(gi), 32'd6);
    for (int i = 0; i < 6; i++)
      if (i < gi) check($sformatf("rr_grant%0d", i), {28'b0, grants[i]}, {28'b0, 4'b0001 << (i % 4)});

    // Backpressure in RESP, then same-edge completion and accept.
    step(4'b0000, 16'h0, 16'h0, 1'b1, 1'b0);
    run_one(0, 4'h5, 4'h3);
    step(4'b0001, 16'h0005, 16'h000D, 1'b1, 1'b1);
    step(4'b0000, 16'h0, 16'h0, 1'b0, 1'b1);
    for (int c = 0; c < 5; c++) step(4'b0010, 16'h0040, 16'h0050, 1'b0, 1'b1);
    check("bp_hold_p", {24'b0, obs_p}, 32'hF1);
    step(4'b0010, 16'h0040, 16'h0050, 1'b1, 1'b1);
    check("bp_accept1", {28'b0, obs_ready}, 32'h2);
    step(4'b0000, 16'h0, 16'h0, 1'b1, 1'b1);
    step(4'b0000, 16'h0, 16'h0, 1'b1, 1'b1);
    check("bp_rsp_p", {24'b0, obs_p}, 32'h14);

    // Reset while in MUL, then requester 3 granted normally.
    step(4'b0001, 16'h0007, 16'h0007, 1'b1, 1'b1);
    step(4'b0000, 16'h0, 16'h0, 1'b1, 1'b0);
    step(4'b0000, 16'h0, 16'h0, 1'b1, 1'b1);
    check("rst_mid_valid", {31'b0, obs_valid}, 32'h0);
    check("rst_mid_p", {24'b0, obs_p}, 32'h0);
    step(4'b1000, 16'h2000, 16'h3000, 1'b1, 1'b1);
    check("rst_req3", {28'b0, obs_ready}, 32'h8);
    step(4'b0000, 16'h0, 16'h0, 1'b1, 1'b1);
    step(4'b0000, 16'h0, 16'h0, 1'b1, 1'b1);
    check("rst_req3_p", {24'b0, obs_p}, 32'h06);

    // Withdrawn request while busy leaves the pointer alone.
    step(4'b0001, 16'h0001, 16'h0001, 1'b1, 1'b1);
    step(4'b0010, 16'h0010, 16'h0010, 1'b1, 1'b1);
    step(4'b0000, 16'h0, 16'h0, 1'b1, 1'b1);
    step(4'b0000, 16'h0, 16'h0, 1'b1, 1'b1);
    step(4'b1111, 16'h0, 16'h0, 1'b1, 1'b1);
    check("withdraw_ptr", {28'b0, obs_ready}, 32'h2);
    step(4'b0000, 16'h0, 16'h0, 1'b1, 1'b1);
    step(4'b0000, 16'h0, 16'h0, 1'b1, 1'b1);

    // Randomized traffic, backpressure and occasional reset.
    for (int c = 0; c < 600; c++)
      step(4'($urandom), 16'($urandom), 16'($urandom),
           $urandom_range(0, 3) != 0, $urandom_range(0, 49) != 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
